// File: rtl/sd_seq_pkg.sv
// Shared state encoding, default register offsets and command words for the SD block sequencer.
package sd_seq_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StWrDma,
    StWrBlkcnt,
    StWrArg,
    StWrCmd,
    StPollCevt,
    StClrCevt,
    StPollDevt,
    StClrDevt,
    StDone
  } seq_state_e;

  localparam logic [7:0]  DefAddrArg    = 8'h00;
  localparam logic [7:0]  DefAddrCmd    = 8'h04;
  localparam logic [7:0]  DefAddrCevt   = 8'h34;
  localparam logic [7:0]  DefAddrDevt   = 8'h3C;
  localparam logic [7:0]  DefAddrBlkcnt = 8'h48;
  localparam logic [7:0]  DefAddrDma    = 8'h60;
  localparam logic [31:0] DefCmdRd      = 32'h0000_1139;
  localparam logic [31:0] DefCmdWr      = 32'h0000_1859;
  localparam logic [15:0] DefTimeoutCyc = 16'hFFFF;

endpackage

// File: rtl/sd_seq_wb_single.sv
// Single-access Wishbone master: one classic cycle per start, outputs frozen until ack.
module sd_seq_wb_single (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        we_i,
  input  logic [7:0]  adr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic        busy_o,
  output logic [31:0] rdata_o,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);

  logic        cyc_q;
  logic        we_q;
  logic [7:0]  adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;

  // A start is only taken while cyc is low, so the ack cycle is always followed by an idle cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
    end else if (!cyc_q && start_i) begin
      cyc_q <= 1'b1;
      we_q  <= we_i;
      adr_q <= adr_i;
      dat_q <= wdata_i;
      sel_q <= 4'hF;
    end else if (cyc_q && wb_ack_i) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      sel_q <= '0;
    end
  end

  assign done_o   = cyc_q && wb_ack_i;
  assign busy_o   = cyc_q;
  assign rdata_o  = wb_dat_i;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;

endmodule

// File: rtl/sd_blk_sequencer.sv
// Sequences one single-block SD transfer over Wishbone; define SD_SEQ_TIMEOUT_EN for a
// per-poll-state cycle timeout.
module sd_blk_sequencer
  import sd_seq_pkg::*;
#(
  parameter logic [7:0]  ADDR_ARG    = DefAddrArg,
  parameter logic [7:0]  ADDR_CMD    = DefAddrCmd,
  parameter logic [7:0]  ADDR_CEVT   = DefAddrCevt,
  parameter logic [7:0]  ADDR_DEVT   = DefAddrDevt,
  parameter logic [7:0]  ADDR_BLKCNT = DefAddrBlkcnt,
  parameter logic [7:0]  ADDR_DMA    = DefAddrDma,
  parameter logic [31:0] CMD_RD      = DefCmdRd,
  parameter logic [31:0] CMD_WR      = DefCmdWr,
  parameter logic [15:0] TIMEOUT_CYC = DefTimeoutCyc
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_lba,
  input  logic [31:0] req_buf,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [15:0] resp_status,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);

  seq_state_e  state_q, state_d;
  logic [31:0] lba_q, buf_q, cevt_q;
  logic [7:0]  devt_q;
  logic        wr_q, tmo_q;

  logic        acc_start, acc_we, acc_done, acc_busy;
  logic [7:0]  acc_adr;
  logic [31:0] acc_wdata, acc_rdata;
  logic        tmo_hit, in_poll;

  assign in_poll = (state_q == StPollCevt) || (state_q == StPollDevt);

`ifdef SD_SEQ_TIMEOUT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!in_poll || (state_d != state_q)) begin
      cnt_q <= '0;
    end else if (!tmo_hit) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign tmo_hit = in_poll && (cnt_q >= TIMEOUT_CYC);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    acc_start = 1'b0;
    acc_we    = 1'b0;
    acc_adr   = '0;
    acc_wdata = '0;
    unique case (state_q)
      StIdle: if (req_valid) state_d = StWrDma;
      StWrDma: begin
        acc_start = 1'b1;
        acc_we    = 1'b1;
        acc_adr   = ADDR_DMA;
        acc_wdata = buf_q;
        if (acc_done) state_d = StWrBlkcnt;
      end
      StWrBlkcnt: begin
        acc_start = 1'b1;
        acc_we    = 1'b1;
        acc_adr   = ADDR_BLKCNT;
        if (acc_done) state_d = StWrArg;
      end
      StWrArg: begin
        acc_start = 1'b1;
        acc_we    = 1'b1;
        acc_adr   = ADDR_ARG;
        acc_wdata = lba_q;
        if (acc_done) state_d = StWrCmd;
      end
      StWrCmd: begin
        acc_start = 1'b1;
        acc_we    = 1'b1;
        acc_adr   = ADDR_CMD;
        acc_wdata = wr_q ? CMD_WR : CMD_RD;
        if (acc_done) state_d = StPollCevt;
      end
      StPollCevt: begin
        acc_start = !tmo_hit;
        acc_adr   = ADDR_CEVT;
        if (acc_done && (acc_rdata != '0)) state_d = StClrCevt;
        else if (tmo_hit && (acc_done || !acc_busy)) state_d = StDone;
      end
      StClrCevt: begin
        acc_start = 1'b1;
        acc_we    = 1'b1;
        acc_adr   = ADDR_CEVT;
        // Any command-event bit besides completion means no data phase will follow.
        if (acc_done) state_d = (|cevt_q[31:1]) ? StDone : StPollDevt;
      end
      StPollDevt: begin
        acc_start = !tmo_hit;
        acc_adr   = ADDR_DEVT;
        if (acc_done && (acc_rdata != '0)) state_d = StClrDevt;
        else if (tmo_hit && (acc_done || !acc_busy)) state_d = StDone;
      end
      StClrDevt: begin
        acc_start = 1'b1;
        acc_we    = 1'b1;
        acc_adr   = ADDR_DEVT;
        if (acc_done) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lba_q   <= '0;
      buf_q   <= '0;
      wr_q    <= 1'b0;
      cevt_q  <= '0;
      devt_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == StIdle) && req_valid) begin
        lba_q  <= req_lba;
        buf_q  <= req_buf;
        wr_q   <= req_write;
        cevt_q <= '0;
        devt_q <= '0;
        tmo_q  <= 1'b0;
      end
      if ((state_q == StPollCevt) && acc_done && (acc_rdata != '0)) cevt_q <= acc_rdata;
      if ((state_q == StPollDevt) && acc_done && (acc_rdata != '0)) devt_q <= acc_rdata[7:0];
      if (in_poll && (state_d == StDone)) tmo_q <= 1'b1;
    end
  end

  assign req_ready   = rst_n && (state_q == StIdle);
  assign resp_valid  = (state_q == StDone);
  assign resp_err    = resp_valid && (tmo_q || (|cevt_q[7:1]) || (|devt_q[7:1]));
  assign resp_status = !resp_valid ? 16'h0000 :
                       tmo_q       ? 16'hFFFF : {devt_q, cevt_q[7:0]};

  sd_seq_wb_single u_wb (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (acc_start),
    .we_i     (acc_we),
    .adr_i    (acc_adr),
    .wdata_i  (acc_wdata),
    .done_o   (acc_done),
    .busy_o   (acc_busy),
    .rdata_o  (acc_rdata),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_ack_i (wb_ack_i)
  );

endmodule
